// File: rtl/cache_ctrl8_if.sv
// Handshake and control bundle between cache_ctrl8 and its CPU, datapath and
// physical-memory neighbours. The master modport is the controller's view.
interface cache_ctrl8_if;
    logic       mem_read;
    logic       mem_write;
    logic       mem_resp;
    logic       hit;
    logic [2:0] hit_way;
    logic [2:0] plru_way;
    logic       victim_valid;
    logic       victim_dirty;
    logic       pmem_resp;
    logic       pmem_read;
    logic       pmem_write;
    logic       pmem_addr_sel;
    logic [2:0] way_sel;
    logic       data_load;
    logic       data_src;
    logic       tag_load;
    logic       valid_set;
    logic       dirty_set;
    logic       dirty_clr;
    logic       plru_load;
    logic [2:0] plru_mru;
    logic       busy;

    modport master (
        input  mem_read, mem_write, hit, hit_way, plru_way,
               victim_valid, victim_dirty, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
               data_load, data_src, tag_load, valid_set, dirty_set,
               dirty_clr, plru_load, plru_mru, busy
    );

    modport slave (
        output mem_read, mem_write, hit, hit_way, plru_way,
               victim_valid, victim_dirty, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel,
               data_load, data_src, tag_load, valid_set, dirty_set,
               dirty_clr, plru_load, plru_mru, busy
    );
endinterface

// File: rtl/cache_ctrl8.sv
// Control FSM for the 8-way, 8-set cache: hit service, victim writeback, line fill.
// Define CACHE_CTRL_PERF_EN to add saturating hit/miss/writeback counters.
module cache_ctrl8 #(
    parameter int s_index = 3,
    parameter int n_ways  = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef CACHE_CTRL_PERF_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count,
`endif
    cache_ctrl8_if.master bus
);

    if (s_index != 3 || n_ways != 8) begin : g_cfg_check
        $error("cache_ctrl8 supports only 8 sets of 8 ways");
    end

    typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

    state_t     state_reg;
    logic [2:0] victim_reg;
    logic       req;

    assign req = bus.mem_read | bus.mem_write;

    // plru_way is sampled only on a miss so WB/FILL keep a stable target way.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            victim_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (req) state_reg <= CHECK;
                CHECK: begin
                    if (!req || bus.hit) begin
                        state_reg <= IDLE;
                    end else begin
                        victim_reg <= bus.plru_way;
                        state_reg  <= (bus.victim_valid && bus.victim_dirty) ? WB : FILL;
                    end
                end
                WB:   if (bus.pmem_resp) state_reg <= FILL;
                FILL: if (bus.pmem_resp) state_reg <= CHECK;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.way_sel       = '0;
        bus.data_load     = 1'b0;
        bus.data_src      = 1'b0;
        bus.tag_load      = 1'b0;
        bus.valid_set     = 1'b0;
        bus.dirty_set     = 1'b0;
        bus.dirty_clr     = 1'b0;
        bus.plru_load     = 1'b0;
        bus.plru_mru      = '0;
        bus.busy          = (state_reg != IDLE);
        case (state_reg)
            CHECK: begin
                if (req && bus.hit) begin
                    bus.mem_resp  = 1'b1;
                    bus.plru_load = 1'b1;
                    bus.plru_mru  = bus.hit_way;
                    bus.way_sel   = bus.hit_way;
                    // A write wins when both request lines are high.
                    if (bus.mem_write) begin
                        bus.data_load = 1'b1;
                        bus.dirty_set = 1'b1;
                    end
                end
            end
            WB: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
                bus.way_sel       = victim_reg;
                bus.dirty_clr     = bus.pmem_resp;
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                bus.way_sel   = victim_reg;
                if (bus.pmem_resp) begin
                    bus.data_load = 1'b1;
                    bus.data_src  = 1'b1;
                    bus.tag_load  = 1'b1;
                    bus.valid_set = 1'b1;
                    bus.dirty_clr = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef CACHE_CTRL_PERF_EN
    logic [2:0] perf_inc;
    logic       refill_reg;

    // Marks a CHECK that follows a fill, so the re-check hit is not counted.
    always_ff @(posedge clk) begin
        if (rst)                                   refill_reg <= 1'b0;
        else if (state_reg == FILL && bus.pmem_resp) refill_reg <= 1'b1;
        else if (state_reg == IDLE)                refill_reg <= 1'b0;
    end

    always_comb begin
        perf_inc    = '0;
        perf_inc[0] = (state_reg == CHECK) && req && bus.hit && !refill_reg;
        perf_inc[1] = (state_reg == CHECK) && req && !bus.hit;
        perf_inc[2] = (state_reg == WB) && bus.pmem_resp;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [31:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (rst)                                cnt_reg <= '0;
            else if (perf_inc[gi] && cnt_reg != '1) cnt_reg <= cnt_reg + 32'd1;
        end
    end

    assign hit_count  = g_cnt[0].cnt_reg;
    assign miss_count = g_cnt[1].cnt_reg;
    assign wb_count   = g_cnt[2].cnt_reg;
`else
    // Without the counters the FSM stands alone; no extra state is kept.
`endif

endmodule

// File: tb/tb_cache_ctrl8.sv
// Self-checking bench for cache_ctrl8: directed scenarios plus random transactions
// checked cycle by cycle against a transaction-level timeline model.
module tb_cache_ctrl8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_ctrl8_if bus();

`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    cache_ctrl8 #(.s_index(3), .n_ways(8)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef CACHE_CTRL_PERF_EN
        .hit_count (hit_count),
        .miss_count(miss_count),
        .wb_count  (wb_count),
`endif
        .bus       (bus)
    );

    typedef struct packed {
        logic       mem_resp;
        logic       pmem_read;
        logic       pmem_write;
        logic       pmem_addr_sel;
        logic [2:0] way_sel;
        logic       data_load;
        logic       data_src;
        logic       tag_load;
        logic       valid_set;
        logic       dirty_set;
        logic       dirty_clr;
        logic       plru_load;
        logic [2:0] plru_mru;
        logic       busy;
    } outs_t;

    int compared   = 0;
    int mismatched = 0;
    int exp_hits   = 0;
    int exp_misses = 0;
    int exp_wbs    = 0;
    int txn_no     = 0;

    function automatic logic rb();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    function automatic logic [2:0] rw();
        logic [31:0] r;
        r = $urandom;
        return r[2:0];
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.mem_resp      = bus.mem_resp;
        o.pmem_read     = bus.pmem_read;
        o.pmem_write    = bus.pmem_write;
        o.pmem_addr_sel = bus.pmem_addr_sel;
        o.way_sel       = bus.way_sel;
        o.data_load     = bus.data_load;
        o.data_src      = bus.data_src;
        o.tag_load      = bus.tag_load;
        o.valid_set     = bus.valid_set;
        o.dirty_set     = bus.dirty_set;
        o.dirty_clr     = bus.dirty_clr;
        o.plru_load     = bus.plru_load;
        o.plru_mru      = bus.plru_mru;
        o.busy          = bus.busy;
        return o;
    endfunction

    // A serviced hit: respond, touch PLRU, and for writes merge CPU data and mark dirty.
    function automatic outs_t hit_outs(input logic [2:0] way, input logic is_write);
        outs_t e;
        e           = '0;
        e.mem_resp  = 1'b1;
        e.plru_load = 1'b1;
        e.plru_mru  = way;
        e.way_sel   = way;
        e.busy      = 1'b1;
        e.data_load = is_write;
        e.dirty_set = is_write;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic h, input logic [2:0] hw,
                         input logic [2:0] pw, input logic vv, input logic vd, input logic pr);
        bus.mem_read     = rd;
        bus.mem_write    = wr;
        bus.hit          = h;
        bus.hit_way      = hw;
        bus.plru_way     = pw;
        bus.victim_valid = vv;
        bus.victim_dirty = vd;
        bus.pmem_resp    = pr;
    endtask

    // Inputs are already applied just after a rising edge; compare on the falling edge.
    task automatic step_check(input string tag, input outs_t exp);
        @(negedge clk);
        check(tag, 32'(sample()), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
`ifdef CACHE_CTRL_PERF_EN
        @(negedge clk);
        check({tag, "_hit_count"},  hit_count,  exp_hits);
        check({tag, "_miss_count"}, miss_count, exp_misses);
        check({tag, "_wb_count"},   wb_count,   exp_wbs);
        @(posedge clk);
        #1;
`else
        $display("counters not built (%s)", tag);
`endif
    endtask

    // kind: 0 = hit, 1 = clean miss, 2 = dirty miss
    task automatic txn(input int kind, input logic rd, input logic wr, input logic [2:0] way,
                       input int lat_wb, input int lat_fill);
        outs_t e;
        logic vv, vd;
        int r;
        txn_no++;
        $display("txn %0d kind=%0d rd=%0b wr=%0b way=%0d lat_wb=%0d lat_fill=%0d",
                 txn_no, kind, rd, wr, way, lat_wb, lat_fill);
        drive(rd, wr, rb(), rw(), rw(), rb(), rb(), rb());
        e = '0;
        step_check("idle_req", e);
        if (kind == 0) begin
            drive(rd, wr, 1'b1, way, rw(), rb(), rb(), 1'b0);
            step_check("hit", hit_outs(way, wr));
            exp_hits++;
        end else begin
            r = $urandom_range(0, 2);
            if (kind == 2) begin
                vv = 1'b1; vd = 1'b1;
            end else begin
                vv = (r == 2); vd = (r == 1);
            end
            drive(rd, wr, 1'b0, rw(), way, vv, vd, 1'b0);
            e = '0;
            e.busy = 1'b1;
            step_check("miss_check", e);
            exp_misses++;
            if (kind == 2) begin
                for (int i = 0; i <= lat_wb; i++) begin
                    drive(rd, wr, rb(), rw(), rw(), rb(), rb(), i == lat_wb);
                    e = '0;
                    e.busy = 1'b1;
                    e.pmem_write = 1'b1;
                    e.pmem_addr_sel = 1'b1;
                    e.way_sel = way;
                    e.dirty_clr = (i == lat_wb);
                    step_check("wb", e);
                end
                exp_wbs++;
            end
            for (int j = 0; j <= lat_fill; j++) begin
                drive(rd, wr, 1'b0, rw(), rw(), rb(), rb(), j == lat_fill);
                e = '0;
                e.busy = 1'b1;
                e.pmem_read = 1'b1;
                e.way_sel = way;
                if (j == lat_fill) begin
                    e.data_load = 1'b1;
                    e.data_src  = 1'b1;
                    e.tag_load  = 1'b1;
                    e.valid_set = 1'b1;
                    e.dirty_clr = 1'b1;
                end
                step_check("fill", e);
            end
            drive(rd, wr, 1'b1, way, rw(), rb(), rb(), 1'b0);
            step_check("recheck", hit_outs(way, wr));
        end
        drive(1'b0, 1'b0, rb(), rw(), rw(), rb(), rb(), rb());
        e = '0;
        step_check("idle_after", e);
    endtask

    initial begin
        outs_t e;
        logic rd, wr;
        int k;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        e = '0;
        step_check("reset_idle", e);
        check_counters("reset");

        txn(0, 1'b1, 1'b0, 3'd5, 0, 0);
        txn(0, 1'b0, 1'b1, 3'd2, 0, 0);
        txn(0, 1'b1, 1'b1, 3'd7, 0, 0);
        txn(1, 1'b1, 1'b0, 3'd3, 0, 4);
        check_counters("clean_miss");
        txn(2, 1'b0, 1'b1, 3'd6, 3, 2);
        txn(2, 1'b1, 1'b0, 3'd0, 0, 0);
        check_counters("dirty_miss");

        // Request dropped during CHECK: back to IDLE with no response.
        txn_no++;
        $display("txn %0d dropped request", txn_no);
        drive(1'b1, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        e = '0;
        step_check("drop_idle", e);
        drive(1'b0, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0);
        e.busy = 1'b1;
        step_check("drop_check", e);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        e = '0;
        step_check("drop_after", e);

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 2);
            rd = rb();
            wr = rb();
            if (!rd && !wr) rd = 1'b1;
            txn(k, rd, wr, rw(), $urandom_range(0, 5), $urandom_range(0, 5));
        end
        check_counters("random");

        // Reset in the middle of a fill abandons it; a late pmem_resp is ignored.
        txn_no++;
        $display("txn %0d reset during fill", txn_no);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0);
        e = '0;
        step_check("rst_idle", e);
        e.busy = 1'b1;
        step_check("rst_miss", e);
        exp_misses++;
        e.pmem_read = 1'b1;
        e.way_sel = 3'd4;
        step_check("rst_fill", e);
        rst = 1'b1;
        step_check("rst_fill_held", e);
        rst = 1'b0;
        exp_hits = 0; exp_misses = 0; exp_wbs = 0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1);
        e = '0;
        step_check("rst_after", e);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0);
        step_check("rst_late_resp", e);
        check_counters("after_rst");

        for (int n = 0; n < 10; n++) begin
            k = $urandom_range(0, 2);
            txn(k, rb(), 1'b1, rw(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        check_counters("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
